// File: rtl/arb_mux_stage.sv
//------------------------------------------------------------------------------
// Module   : arb_mux_stage
// Purpose  : NUM_IN:1 data selector with a registered output stage and
//            valid/ready handshakes. Channel choice is either an external
//            select (mode=0) or a fair round-robin among valid inputs (mode=1).
//            One cycle of latency, full throughput, back-pressure capable.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            mode, sel         - selection mode and fixed-mode channel index
//            inValid/inReady   - per-channel handshake (inReady one-hot or 0)
//            inData            - channel i at [i*WIDTH +: WIDTH]
//            outValid/outReady - output handshake
//            outData, outChan  - registered word and its source channel
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_mux_stage #(
   parameter int  WIDTH  = 8,
   parameter int  NUM_IN = 4,
   localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN-1:0]       inValid,
   output logic [NUM_IN-1:0]       inReady,
   input  logic [NUM_IN*WIDTH-1:0] inData,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [WIDTH-1:0]        outData,
   output logic [SEL_W-1:0]        outChan
);

   // Valid vector padded to the full select range so an out-of-range
   // fixed select reads a zero instead of indexing past the port.
   localparam int c_PAD_W = 1 << SEL_W;

   logic [SEL_W-1:0]   r_ptr;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]   r_out_chan;

   logic [c_PAD_W-1:0] w_valid_pad;
   logic               w_load_en;
   logic               w_rr_found;
   logic [SEL_W-1:0]   w_rr_idx;
   logic [SEL_W:0]     w_cand;
   logic               w_grant;
   logic [SEL_W-1:0]   w_gidx;
   logic [WIDTH-1:0]   w_sel_data;
   logic [NUM_IN-1:0]  w_ready;

   assign w_valid_pad = c_PAD_W'(inValid);

   // Register can take a new word when empty or being drained this cycle.
   assign w_load_en = !r_out_valid || outReady;

   // Round-robin search: ptr+1, ptr+2, ... ptr, wrapped modulo NUM_IN by a
   // single conditional subtract (sum never exceeds 2*NUM_IN-1).
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      w_cand     = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         w_cand = {1'b0, r_ptr} + (SEL_W+1)'(k);
         if (w_cand >= (SEL_W+1)'(NUM_IN)) begin
            w_cand = w_cand - (SEL_W+1)'(NUM_IN);
         end
         if (!w_rr_found && w_valid_pad[w_cand[SEL_W-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_cand[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      w_grant = 1'b0;
      w_gidx  = '0;
      if (mode) begin
         w_grant = w_rr_found;
         w_gidx  = w_rr_idx;
      end else begin
         w_grant = w_valid_pad[sel];
         w_gidx  = w_valid_pad[sel] ? sel : '0;
      end
   end

   assign w_sel_data = inData[w_gidx*WIDTH +: WIDTH];

   always_comb begin
      w_ready = '0;
      if (!rst && w_load_en && w_grant) begin
         w_ready[w_gidx] = 1'b1;
      end
   end

   assign inReady = w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_ptr       <= SEL_W'(NUM_IN - 1);
      end else if (w_load_en) begin
         if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gidx;
            if (mode) begin
               r_ptr <= w_gidx;
            end
         end else begin
            // Drain without refill: data and channel keep their last values.
            r_out_valid <= 1'b0;
         end
      end
   end

   assign outValid = r_out_valid;
   assign outData  = r_out_data;
   assign outChan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_arb_mux_stage
// Purpose  : Self-checking bench for arb_mux_stage. Two instances (NUM_IN=4
//            and NUM_IN=3) are driven with directed and random traffic and
//            compared each cycle against a behavioural reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arb_mux_stage;

   logic        clk;
   logic        rst;

   // NUM_IN = 4 instance
   logic        mode4;
   logic [1:0]  sel4;
   logic [3:0]  v4;
   logic [3:0]  rdy4;
   logic [31:0] d4;
   logic        ov4;
   logic        ordy4;
   logic [7:0]  od4;
   logic [1:0]  oc4;

   // NUM_IN = 3 instance
   logic        mode3;
   logic [1:0]  sel3;
   logic [2:0]  v3;
   logic [2:0]  rdy3;
   logic [23:0] d3;
   logic        ov3;
   logic        ordy3;
   logic [7:0]  od3;
   logic [1:0]  oc3;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state per instance (0 -> NUM_IN=4, 1 -> NUM_IN=3)
   bit       m_valid [2] = '{0, 0};
   bit [7:0] m_data  [2] = '{0, 0};
   int       m_chan  [2] = '{0, 0};
   int       m_ptr   [2] = '{3, 2};

   arb_mux_stage #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
      .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
      .inValid(v4), .inReady(rdy4), .inData(d4),
      .outValid(ov4), .outReady(ordy4), .outData(od4), .outChan(oc4)
   );

   arb_mux_stage #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
      .inValid(v3), .inReady(rdy3), .inData(d3),
      .outValid(ov3), .outReady(ordy3), .outData(od3), .outChan(oc3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Grant from the rules: fixed index if in range and valid, else first
   // valid channel after the pointer going round the ring; -1 = no grant.
   function automatic int ref_grant(int n, bit md, int s, logic [3:0] v, int p);
      if (!md) return (s < n && v[s]) ? s : -1;
      for (int k = 1; k <= n; k++) begin
         int c;
         c = (p + k) % n;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // One clock: check ready before the edge, advance the model, check outputs.
   task automatic step();
      int          g   [2];
      bit          le  [2];
      bit          md  [2];
      logic [31:0] dat [2];
      int          n;
      int          s;
      logic [3:0]  v;
      logic [3:0]  act;
      bit          ordy;
      #1;
      for (int i = 0; i < 2; i++) begin
         n      = (i == 0) ? 4 : 3;
         md[i]  = (i == 0) ? mode4 : mode3;
         s      = (i == 0) ? int'(sel4) : int'(sel3);
         v      = (i == 0) ? v4 : {1'b0, v3};
         act    = (i == 0) ? rdy4 : {1'b0, rdy3};
         ordy   = (i == 0) ? ordy4 : ordy3;
         dat[i] = (i == 0) ? d4 : {8'h00, d3};
         le[i]  = !m_valid[i] || ordy;
         g[i]   = ref_grant(n, md[i], s, v, m_ptr[i]);
         chk($sformatf("inReady[n%0d]", n), {28'h0, act},
             (!rst && le[i] && g[i] >= 0) ? (32'd1 << g[i]) : 32'd0);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_valid[i] = 0;
            m_data[i]  = 8'h00;
            m_chan[i]  = 0;
            m_ptr[i]   = (i == 0) ? 3 : 2;
         end else if (le[i]) begin
            if (g[i] >= 0) begin
               m_valid[i] = 1;
               m_data[i]  = dat[i][g[i]*8 +: 8];
               m_chan[i]  = g[i];
               if (md[i]) m_ptr[i] = g[i];
            end else begin
               m_valid[i] = 0;
            end
         end
      end
      #1;
      chk("outValid[n4]", {31'h0, ov4}, {31'h0, m_valid[0]});
      chk("outData[n4]",  {24'h0, od4}, {24'h0, m_data[0]});
      chk("outChan[n4]",  {30'h0, oc4}, 32'(m_chan[0]));
      chk("outValid[n3]", {31'h0, ov3}, {31'h0, m_valid[1]});
      chk("outData[n3]",  {24'h0, od3}, {24'h0, m_data[1]});
      chk("outChan[n3]",  {30'h0, oc3}, 32'(m_chan[1]));
   endtask

   initial begin
      rst = 1'b1;
      mode4 = 1'b0; sel4 = 2'd0; v4 = 4'h0; d4 = 32'h0; ordy4 = 1'b1;
      mode3 = 1'b0; sel3 = 2'd0; v3 = 3'h0; d3 = 24'h0; ordy3 = 1'b1;

      // 1: reset two cycles, then fixed select of channel 2
      step();
      step();
      chk("rst_outValid", {31'h0, ov4}, 32'd0);
      rst = 1'b0;
      mode4 = 1'b0; sel4 = 2'd2; v4 = 4'b0100; d4 = 32'h00A5_0000;
      #1;
      chk("tp1_inReady", {28'h0, rdy4}, 32'h4);
      step();
      chk("tp1_outData", {24'h0, od4}, 32'hA5);
      chk("tp1_outChan", {30'h0, oc4}, 32'd2);

      // 2: round-robin fairness, all channels valid
      mode4 = 1'b1; v4 = 4'b1111; d4 = 32'h1312_1110;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("tp2_chan", {30'h0, oc4}, 32'(i % 4));
         chk("tp2_data", {24'h0, od4}, 32'(8'h10 + i % 4));
      end

      // 3: skip and wrap, last grant ch3
      v4 = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("tp3_chan", {30'h0, oc4}, (i == 1) ? 32'd3 : 32'd1);
      end

      // 4: back-pressure with 3C held, then no-bubble refill
      mode4 = 1'b0; sel4 = 2'd0; v4 = 4'b0001; d4 = 32'h4443_423C;
      step();
      mode4 = 1'b1; v4 = 4'b1111; ordy4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("tp4_hold", {24'h0, od4}, 32'h3C);
      end
      ordy4 = 1'b1;
      step();
      chk("tp4_refill_chan", {30'h0, oc4}, 32'd2);
      chk("tp4_refill_valid", {31'h0, ov4}, 32'd1);

      // 5: NUM_IN=3, out-of-range select, held word drains
      mode3 = 1'b0; sel3 = 2'd0; v3 = 3'b001; d3 = 24'h7766_55;
      step();
      sel3 = 2'd3; v3 = 3'b111;
      step();
      chk("tp5_drain", {31'h0, ov3}, 32'd0);
      step();

      // 6: reset mid-stall, then mode 1 -> 0 -> 1 with ptr=1
      mode4 = 1'b0; sel4 = 2'd1; v4 = 4'b0010;
      step();
      ordy4 = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("tp6_rst_valid", {31'h0, ov4}, 32'd0);
      rst = 1'b0; ordy4 = 1'b1; mode4 = 1'b1; v4 = 4'b1111;
      step();
      step();
      chk("tp6_ptr1", {30'h0, oc4}, 32'd1);
      mode4 = 1'b0; sel4 = 2'd3;
      step();
      mode4 = 1'b1;
      step();
      chk("tp6_resume", {30'h0, oc4}, 32'd2);

      // Random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 49) == 0);
         mode4 = 1'($urandom);
         sel4  = 2'($urandom);
         v4    = 4'($urandom);
         d4    = $urandom;
         ordy4 = ($urandom_range(0, 3) != 0);
         mode3 = 1'($urandom);
         sel3  = 2'($urandom);
         v3    = 3'($urandom);
         d3    = 24'($urandom);
         ordy3 = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
